// File: rtl/rx_huge_page_sequencer.sv
// RX huge-page sequencer: alternates between two host-provided huge pages,
// hands out chunk write addresses to the TLP builder, and reports each page
// close before returning it to upstream with a one-cycle free pulse.
// Optional build macro: RX_PAGE_TIMEOUT_EN closes a partly filled page after
// TIMEOUT_CYCLES idle cycles.
module rx_huge_page_sequencer #(
  parameter int unsigned PAGE_SIZE_LOG2 = 21,
  parameter int unsigned TIMEOUT_CYCLES = 25000
) (
  input  logic                      trn_clk,
  input  logic                      reset,
  input  logic [63:0]               huge_page_addr_1,
  input  logic [63:0]               huge_page_addr_2,
  input  logic                      huge_page_status_1,
  input  logic                      huge_page_status_2,
  output logic                      huge_page_free_1,
  output logic                      huge_page_free_2,
  input  logic                      chunk_req,
  input  logic [12:0]               chunk_len,
  output logic                      chunk_gnt,
  output logic [63:0]               chunk_addr,
  input  logic                      chunk_done,
  input  logic                      flush,
  output logic                      close_valid,
  output logic                      close_page,
  output logic [63:0]               close_addr,
  output logic [PAGE_SIZE_LOG2:0]   close_bytes,
  input  logic                      close_rdy
);

  localparam int unsigned OffW = PAGE_SIZE_LOG2 + 1;
  // Wide enough that offset + rounded length can never wrap.
  localparam int unsigned SumW = PAGE_SIZE_LOG2 + 15;
  localparam logic [OffW-1:0] PageBytes = {1'b1, {PAGE_SIZE_LOG2{1'b0}}};

  typedef enum logic [2:0] {StWait, StArmed, StBusy, StClose, StFree} state_e;

  state_e          state_q, state_d;
  logic            cur_q, cur_d;
  logic [63:0]     base_q, base_d;
  logic [OffW-1:0] offset_q, offset_d;
  logic [13:0]     len_q, len_d;
  logic            gnt_q, gnt_d;
  logic [63:0]     addr_q, addr_d;

  logic [13:0]     len_rnd;
  logic            fits;
  logic            status_cur;
  logic [63:0]     addr_cur;
  logic            timeout_hit;

  // Round the request up to 8 bytes so the fill offset stays 8-byte aligned.
  assign len_rnd    = ({1'b0, chunk_len} + 14'd7) & ~14'd7;
  assign fits       = (SumW'(offset_q) + SumW'(len_rnd)) <= SumW'(PageBytes);
  assign status_cur = cur_q ? huge_page_status_2 : huge_page_status_1;
  assign addr_cur   = cur_q ? huge_page_addr_2 : huge_page_addr_1;

`ifdef RX_PAGE_TIMEOUT_EN
  logic [31:0] idle_cnt_q, idle_cnt_d;
  logic        idle_run;

  assign idle_run    = (state_q == StArmed) && (offset_q != '0) && !chunk_req;
  assign timeout_hit = idle_run && (idle_cnt_q == TIMEOUT_CYCLES - 1);
  // Count only while idle in the armed state; any exit or request clears it.
  assign idle_cnt_d  = (idle_run && (state_d == StArmed)) ? idle_cnt_q + 32'd1 : 32'd0;

  // Idle counter register.
  always_ff @(posedge trn_clk) begin
    if (reset) idle_cnt_q <= '0;
    else       idle_cnt_q <= idle_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge trn_clk) begin
    if (reset) begin
      state_q  <= StWait;
      cur_q    <= 1'b0;
      base_q   <= '0;
      offset_q <= '0;
      len_q    <= '0;
      gnt_q    <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      base_q   <= base_d;
      offset_q <= offset_d;
      len_q    <= len_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    base_d   = base_q;
    offset_d = offset_q;
    len_d    = len_q;
    gnt_d    = 1'b0;
    addr_d   = addr_q;
    unique case (state_q)
      StWait: begin
        if (status_cur) begin
          base_d   = addr_cur;
          offset_d = '0;
          state_d  = StArmed;
        end
      end
      StArmed: begin
        if ((flush && (offset_q != '0)) || timeout_hit) begin
          state_d = StClose;
        end else if (chunk_req && fits) begin
          gnt_d   = 1'b1;
          addr_d  = base_q + 64'(offset_q);
          len_d   = len_rnd;
          state_d = StBusy;
        end else if (chunk_req) begin
          // Request stays pending and is granted on the next page.
          state_d = StClose;
        end
      end
      StBusy: begin
        if (chunk_done) begin
          offset_d = offset_q + OffW'(len_q);
          state_d  = (offset_d == PageBytes) ? StClose : StArmed;
        end
      end
      StClose: begin
        if (close_rdy) state_d = StFree;
      end
      StFree: begin
        cur_d   = ~cur_q;
        state_d = StWait;
      end
      default: state_d = StWait;
    endcase
  end

  // Output decode; close fields are held stable for the whole close handshake.
  always_comb begin
    chunk_gnt        = gnt_q;
    chunk_addr       = addr_q;
    close_valid      = (state_q == StClose);
    close_page       = close_valid ? cur_q : 1'b0;
    close_addr       = close_valid ? base_q : '0;
    close_bytes      = close_valid ? offset_q : '0;
    huge_page_free_1 = (state_q == StFree) && !cur_q;
    huge_page_free_2 = (state_q == StFree) && cur_q;
  end

endmodule

// File: tb/tb_rx_huge_page_sequencer.sv
// Directed bench for rx_huge_page_sequencer with 4 KB pages.
module tb_rx_huge_page_sequencer;

  localparam int unsigned PSL = 12;
  localparam int unsigned TO  = 100;

  logic          trn_clk = 1'b0;
  logic          reset;
  logic [63:0]   huge_page_addr_1, huge_page_addr_2;
  logic          huge_page_status_1, huge_page_status_2;
  logic          huge_page_free_1, huge_page_free_2;
  logic          chunk_req;
  logic [12:0]   chunk_len;
  logic          chunk_gnt;
  logic [63:0]   chunk_addr;
  logic          chunk_done;
  logic          flush;
  logic          close_valid;
  logic          close_page;
  logic [63:0]   close_addr;
  logic [PSL:0]  close_bytes;
  logic          close_rdy;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned free1_cnt = 0;
  int unsigned free2_cnt = 0;

  rx_huge_page_sequencer #(
    .PAGE_SIZE_LOG2 (PSL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .trn_clk            (trn_clk),
    .reset              (reset),
    .huge_page_addr_1   (huge_page_addr_1),
    .huge_page_addr_2   (huge_page_addr_2),
    .huge_page_status_1 (huge_page_status_1),
    .huge_page_status_2 (huge_page_status_2),
    .huge_page_free_1   (huge_page_free_1),
    .huge_page_free_2   (huge_page_free_2),
    .chunk_req          (chunk_req),
    .chunk_len          (chunk_len),
    .chunk_gnt          (chunk_gnt),
    .chunk_addr         (chunk_addr),
    .chunk_done         (chunk_done),
    .flush              (flush),
    .close_valid        (close_valid),
    .close_page         (close_page),
    .close_addr         (close_addr),
    .close_bytes        (close_bytes),
    .close_rdy          (close_rdy)
  );

  always #5 trn_clk = ~trn_clk;

  // Tally free pulses for the no-spurious-free checks.
  always @(posedge trn_clk) begin
    if (huge_page_free_1) free1_cnt++;
    if (huge_page_free_2) free2_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Request a chunk, expect a grant at exp_addr, then complete it. Called at a negedge.
  task automatic do_chunk(input logic [12:0] len, input logic [63:0] exp_addr,
                          input string tag);
    bit seen;
    seen      = 1'b0;
    chunk_req = 1'b1;
    chunk_len = len;
    for (int i = 0; i < 50; i++) begin
      @(negedge trn_clk);
      if (chunk_gnt) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, " gnt"}, 64'(seen), 64'd1);
    check({tag, " addr"}, chunk_addr, exp_addr);
    chunk_req  = 1'b0;
    chunk_done = 1'b1;
    @(negedge trn_clk);
    chunk_done = 1'b0;
    check({tag, " gnt pulse"}, 64'(chunk_gnt), 64'd0);
  endtask

  // Wait for a close record and compare its fields.
  task automatic expect_close(input bit page, input logic [63:0] addr, input int unsigned bytes,
                              input string tag);
    for (int i = 0; i < 20; i++) begin
      if (close_valid) break;
      @(negedge trn_clk);
    end
    check({tag, " valid"}, 64'(close_valid), 64'd1);
    check({tag, " page"}, 64'(close_page), 64'(page));
    check({tag, " addr"}, close_addr, addr);
    check({tag, " bytes"}, 64'(close_bytes), 64'(bytes));
  endtask

  // Accept the close record and expect exactly one free pulse on the right page.
  task automatic accept_close(input bit page, input string tag);
    close_rdy = 1'b1;
    @(negedge trn_clk);
    close_rdy = 1'b0;
    check({tag, " free1"}, 64'(huge_page_free_1), 64'(!page));
    check({tag, " free2"}, 64'(huge_page_free_2), 64'(page));
    check({tag, " valid drop"}, 64'(close_valid), 64'd0);
    @(negedge trn_clk);
    check({tag, " free end"}, 64'(huge_page_free_1 | huge_page_free_2), 64'd0);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge trn_clk);
    flush = 1'b0;
  endtask

  initial begin
    bit          any;
    int unsigned first;
    int unsigned f1, f2;

    reset = 1'b1;
    huge_page_addr_1 = '0;  huge_page_addr_2 = '0;
    huge_page_status_1 = 1'b0;  huge_page_status_2 = 1'b0;
    chunk_req = 1'b0;  chunk_len = '0;  chunk_done = 1'b0;
    flush = 1'b0;  close_rdy = 1'b0;
    repeat (3) @(negedge trn_clk);
    check("rst gnt", 64'(chunk_gnt), 64'd0);
    check("rst addr", chunk_addr, 64'd0);
    check("rst close_valid", 64'(close_valid), 64'd0);
    check("rst close_bytes", 64'(close_bytes), 64'd0);
    check("rst free1", 64'(huge_page_free_1), 64'd0);
    check("rst free2", 64'(huge_page_free_2), 64'd0);
    reset = 1'b0;

    // Basic grants on page 1; 60 rounds up to 64.
    huge_page_addr_1 = 64'h1_0000_0000;
    huge_page_status_1 = 1'b1;
    do_chunk(13'd64, 64'h1_0000_0000, "basic0");
    do_chunk(13'd60, 64'h1_0000_0040, "basic1");
    do_chunk(13'd8,  64'h1_0000_0080, "basic2");

    // Flush at offset 136 with close_rdy held off for 10 cycles.
    pulse_flush();
    expect_close(1'b0, 64'h1_0000_0000, 136, "bp close");
    for (int i = 0; i < 10; i++) begin
      @(negedge trn_clk);
      check("bp valid", 64'(close_valid), 64'd1);
      check("bp page", 64'(close_page), 64'd0);
      check("bp addr", close_addr, 64'h1_0000_0000);
      check("bp bytes", 64'(close_bytes), 64'd136);
    end
    check("bp no free", 64'(free1_cnt + free2_cnt), 64'd0);
    accept_close(1'b0, "bp");
    huge_page_status_1 = 1'b0;

    // Page 2: flush at offset 0 is ignored, flush at 256 closes.
    huge_page_addr_2 = 64'h2_0000_0000;
    huge_page_status_2 = 1'b1;
    repeat (3) @(negedge trn_clk);
    pulse_flush();
    any = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (close_valid) any = 1'b1;
      @(negedge trn_clk);
    end
    check("flush0 no close", 64'(any), 64'd0);
    for (int i = 0; i < 4; i++) do_chunk(13'd64, 64'h2_0000_0000 + 64'(64 * i), "flush chunk");
    pulse_flush();
    expect_close(1'b1, 64'h2_0000_0000, 256, "flush256 close");
    accept_close(1'b1, "flush256");
    huge_page_status_2 = 1'b0;

    // Fill page 1 to exactly 4096 bytes.
    huge_page_addr_1 = 64'h3_0000_0000;
    huge_page_status_1 = 1'b1;
    for (int i = 0; i < 64; i++) do_chunk(13'd64, 64'h3_0000_0000 + 64'(64 * i), "fill");
    expect_close(1'b0, 64'h3_0000_0000, 4096, "full close");
    accept_close(1'b0, "full");
    huge_page_status_1 = 1'b0;
    // Nothing is granted while page 2 is not yet handed over.
    chunk_req = 1'b1;
    chunk_len = 13'd64;
    any = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge trn_clk);
      if (chunk_gnt) any = 1'b1;
    end
    chunk_req = 1'b0;
    check("wait no gnt", 64'(any), 64'd0);

    // Page 2 to 4032 bytes, then a 128-byte request overflows.
    huge_page_addr_2 = 64'h4_0000_0000;
    huge_page_status_2 = 1'b1;
    for (int i = 0; i < 63; i++) do_chunk(13'd64, 64'h4_0000_0000 + 64'(64 * i), "ovf fill");
    chunk_req = 1'b1;
    chunk_len = 13'd128;
    any = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge trn_clk);
      if (chunk_gnt) any = 1'b1;
      if (close_valid) break;
    end
    check("ovf no gnt", 64'(any), 64'd0);
    expect_close(1'b1, 64'h4_0000_0000, 4032, "ovf close");
    accept_close(1'b1, "ovf");
    huge_page_status_2 = 1'b0;
    repeat (3) @(negedge trn_clk);
    check("ovf pending", 64'(chunk_gnt), 64'd0);
    huge_page_addr_1 = 64'h5_0000_0000;
    huge_page_status_1 = 1'b1;
    do_chunk(13'd128, 64'h5_0000_0000, "ovf regrant");

    // Reset while a grant is outstanding.
    chunk_req = 1'b1;
    chunk_len = 13'd64;
    any = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge trn_clk);
      if (chunk_gnt) begin
        any = 1'b1;
        break;
      end
    end
    chunk_req = 1'b0;
    check("busy gnt", 64'(any), 64'd1);
    check("busy addr", chunk_addr, 64'h5_0000_0080);
    f1 = free1_cnt;
    f2 = free2_cnt;
    reset = 1'b1;
    @(negedge trn_clk);
    check("mid rst gnt", 64'(chunk_gnt), 64'd0);
    check("mid rst addr", chunk_addr, 64'd0);
    check("mid rst close", 64'(close_valid), 64'd0);
    check("mid rst free", 64'(huge_page_free_1 | huge_page_free_2), 64'd0);
    repeat (2) @(negedge trn_clk);
    reset = 1'b0;
    repeat (4) @(negedge trn_clk);
    check("mid rst no free", 64'((free1_cnt - f1) + (free2_cnt - f2)), 64'd0);
    do_chunk(13'd64, 64'h5_0000_0000, "post rst");

    // Idle with a partly filled page.
    first = 0;
    for (int i = 1; i <= 150; i++) begin
      @(negedge trn_clk);
      if (close_valid && first == 0) first = i;
    end
`ifdef RX_PAGE_TIMEOUT_EN
    check("timeout cycle", 64'(first), 64'd100);
`else
    check("no timeout", 64'(first), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_huge_page_sequencer.md
Name: rx_huge_page_sequencer

Overview:
- Downstream consumer of the huge-page address/status block on the RX DMA path.
- Owns the two host-provided huge pages and alternates between them (page 1, page 2, page 1, ...).
- Hands out write addresses for each frame chunk to the RX TLP builder and tracks the fill offset.
- When a page is full, flushed or timed out: reports the close to the bookkeeping writer, then pulses huge_page_free_x so upstream clears that page's status.

Parameters:
PAGE_SIZE_LOG2, 21, log2 of huge page size in bytes (2 MB).
TIMEOUT_CYCLES, 25000, idle cycles before a partly filled page is closed; used only with RX_PAGE_TIMEOUT_EN.

Ports:
trn_clk  in  1  clock
reset  in  1  synchronous, active-high
huge_page_addr_1  in  64  page 1 base byte address
huge_page_addr_2  in  64  page 2 base byte address
huge_page_status_1  in  1  1 = page 1 handed to hardware
huge_page_status_2  in  1  1 = page 2 handed to hardware
huge_page_free_1  out  1  one-cycle pulse: page 1 returned to host
huge_page_free_2  out  1  one-cycle pulse: page 2 returned to host
chunk_req  in  1  level; TLP builder requests space
chunk_len  in  13  requested bytes, 1..4096
chunk_gnt  out  1  one-cycle grant pulse
chunk_addr  out  64  granted write address; valid with chunk_gnt, held until next grant
chunk_done  in  1  one-cycle pulse: granted chunk fully written
flush  in  1  one-cycle pulse: close current page if non-empty
close_valid  out  1  close record valid
close_page  out  1  0 = page 1, 1 = page 2
close_addr  out  64  base address of the closed page
close_bytes  out  PAGE_SIZE_LOG2+1  bytes used in the closed page
close_rdy  in  1  close record accepted

Behaviour:
- Reset: synchronous, active-high, clock trn_clk.
  - All outputs 0; state S_WAIT; cur = 0 (page 1); offset = 0; base_r = 0.
  - Reset mid-operation abandons the page with no free pulse.
- len_rnd = chunk_len rounded up to a multiple of 8. offset is PAGE_SIZE_LOG2+1 bits; it advances only by len_rnd, so it stays 8-byte aligned.
- S_WAIT:
  - When status[cur] = 1: base_r <= addr[cur], offset <= 0, go to S_ARMED.
  - chunk_req is ignored.
- S_ARMED, evaluated in priority order:
  1. flush with offset != 0 -> S_CLOSE.
  2. chunk_req with offset + len_rnd <= 2^PAGE_SIZE_LOG2 -> registered: chunk_gnt = 1 for one cycle, chunk_addr = base_r + offset, len_r latched; go to S_BUSY.
  3. chunk_req that does not fit -> S_CLOSE. The request stays pending and is granted on the next page.
  4. flush with offset = 0 -> ignored.
- S_BUSY:
  - On chunk_done: offset <= offset + len_r. Go to S_CLOSE if the new offset = 2^PAGE_SIZE_LOG2, otherwise S_ARMED.
  - chunk_req and flush are ignored. A flush pulse arriving in this state is lost.
- S_CLOSE:
  - close_valid = 1; close_page = cur, close_addr = base_r, close_bytes = offset, all stable.
  - On close_rdy: drop close_valid, go to S_FREE.
- S_FREE:
  - huge_page_free[cur] = 1 for exactly one cycle.
  - cur toggles; go to S_WAIT.
- A late status on the other page is harmless: only status[cur] is sampled, and only in S_WAIT.
- Grant latency: chunk_gnt is asserted the cycle after chunk_req is sampled in S_ARMED.
- Minimum gap between grants: grant, chunk_done, ARMED, grant.
- The sum base_r + offset is a 64-bit add with carry; no page-crossing check beyond the size compare.

Optional Feature:
- Macro: RX_PAGE_TIMEOUT_EN.
- When defined:
  - Idle counter runs in S_ARMED while offset != 0 and chunk_req = 0.
  - The counter clears on any grant, on chunk_req, and on leaving S_ARMED.
  - When the count reaches TIMEOUT_CYCLES - 1, go to S_CLOSE (same priority as flush).
- When undefined: no counter logic; pages close only on full, overflow or flush. TIMEOUT_CYCLES is unused.

Test Plan:
1. Basic grants (PAGE_SIZE_LOG2 = 12):
   - Stimulus: status_1 = 1, addr_1 = 0x1_0000_0000; then requests of len 64, 60, 8, each followed by chunk_done.
   - Required: grant addresses 0x1_0000_0000, 0x1_0000_0040, 0x1_0000_0080 (60 rounds to 64).
2. Fill to full:
   - Stimulus: 64 requests of len 64, then close_rdy = 1.
   - Required: after the 64th chunk_done, close_valid with page 0 and bytes 4096; then a single-cycle free_1; then the block waits on status_2.
3. Overflow:
   - Stimulus: offset 4032, request len 128; then status_2 = 1 with addr_2 = 0x2_0000_0000.
   - Required: no grant; close with bytes 4032; free_1 pulse; the pending request is granted at 0x2_0000_0000.
4. Flush:
   - Stimulus: flush at offset 0, then flush at offset 256.
   - Required: the first flush produces no close; the second closes with bytes 256 and a following free pulse.
5. Back-pressure:
   - Stimulus: close_rdy held low for 10 cycles.
   - Required: close_valid and all close fields stable; no free pulse until close_rdy is high.
6. Timeout and reset:
   - With the macro and TIMEOUT_CYCLES = 100: one 64-byte chunk, then idle -> close_valid asserted 100 cycles later; without the macro, never asserted.
   - Reset in S_BUSY -> all outputs 0, no free pulse.
